vec_rev_stream: RTL and testbench

Streaming, parametrised successor to the 8-bit combinational vector reverser. Accepts WIDTH-bit words over a valid/ready handshake. Applies a per-word selectable permutation: pass, full bit reverse, byte swap, or bit reverse within each byte. Emits results through a registered output stage with a skid buffer, so both handshake sides are register-driven. It sits between any two streaming blocks in the datapath and also keeps a running transfer count.

---
 rtl/vec_rev_pkg.sv | 22 ++
 rtl/vec_rev_map.sv | 45 ++++
 rtl/vec_rev_stream.sv | 99 +++++++++
 tb/tb_vec_rev_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_rev_pkg.sv
// Shared definitions for the vec_rev_stream block.
// - mode_t: per-word permutation selector carried alongside each input word.
// - MODE_*: the four permutation encodings.
// - state_t: handshake occupancy, encoded as {out_valid, skid_valid}.
package vec_rev_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS        = 2'b00;
  localparam mode_t MODE_BITREV      = 2'b01;
  localparam mode_t MODE_BYTESWAP    = 2'b10;
  localparam mode_t MODE_BITREV_BYTE = 2'b11;

  // Encoding matches the register pair it is derived from, so the state is
  // a pure relabelling of existing flops rather than an extra register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

endpackage

// File: rtl/vec_rev_map.sv
// Combinational word permutation.
// Ports:
//   in_data  [WIDTH-1:0]  word to permute
//   in_mode  [1:0]        permutation select (see vec_rev_pkg)
//   out_data [WIDTH-1:0]  permuted word
module vec_rev_map
  import vec_rev_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic [WIDTH-1:0] out_data
);

  localparam int NBYTES = WIDTH / 8;

  always_comb begin
    // NOTE: assigning a default first means every path writes out_data, so
    // no latch can be inferred whatever the case/loop structure below does.
    out_data = in_data;
    case (mode_t'(in_mode))
      MODE_PASS: out_data = in_data;
      MODE_BITREV: begin
        for (int i = 0; i < WIDTH; i++) begin
          out_data[i] = in_data[WIDTH-1-i];
        end
      end
      MODE_BYTESWAP: begin
        for (int k = 0; k < NBYTES; k++) begin
          out_data[8*k +: 8] = in_data[8*(NBYTES-1-k) +: 8];
        end
      end
      MODE_BITREV_BYTE: begin
        for (int k = 0; k < NBYTES; k++) begin
          for (int b = 0; b < 8; b++) begin
            out_data[8*k+b] = in_data[8*k+7-b];
          end
        end
      end
      default: out_data = in_data;
    endcase
  end

endmodule

// File: rtl/vec_rev_stream.sv
// Streaming word permuter with a registered output stage and one-entry skid
// buffer, plus a running count of completed output transfers.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_data/in_mode         input word and its permutation select
//   in_valid/in_ready       upstream handshake (in_ready is flop-driven)
//   out_data/out_valid      permuted word from the output register
//   out_ready               downstream accept
//   xfer_count              output transfers modulo 2^COUNT_W
module vec_rev_stream
  import vec_rev_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] xfer_count
);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("vec_rev_stream: WIDTH must be a multiple of 8 and at least 8");
  end

  logic [WIDTH-1:0] mapped;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_xfer;
  logic             out_xfer;
  state_t           state;

  // Permute on the way in so the mode travels with its word and later mode
  // changes cannot touch anything already accepted.
  vec_rev_map #(.WIDTH(WIDTH)) u_map (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_data (mapped)
  );

  assign state    = state_t'({out_valid, skid_valid});
  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      xfer_count <= '0;
      // NOTE: skid_data is pure storage qualified by skid_valid, so it is
      // deliberately left out of reset.
    end else begin
      if (out_xfer) begin
        xfer_count <= xfer_count + 1'b1;
      end
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_data  <= mapped;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_data  <= mapped;
            skid_valid <= 1'b1;
          end else if (in_xfer && out_xfer) begin
            out_data <= mapped;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          // {0,1} is unreachable; fall back to empty.
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_rev_stream.sv
module tb_vec_rev_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_count;

  logic        w_in_ready;
  logic [31:0] w_out_data;
  logic        w_out_valid;
  logic [3:0]  w_xfer_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  vec_rev_stream #(.WIDTH(32), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  // Same stimulus, narrow counter, used for the wrap-around check.
  vec_rev_stream #(.WIDTH(32), .COUNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(w_in_ready), .out_data(w_out_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .xfer_count(w_xfer_count)
  );

  // Reference permutation built from streaming operators.
  function automatic logic [31:0] ref_perm(logic [31:0] d, logic [1:0] m);
    logic [31:0] r;
    logic [31:0] s;
    case (m)
      2'b00: r = d;
      2'b01: r = {<<{d}};
      2'b10: r = {<<8{d}};
      default: begin
        s = {<<8{d}};
        r = {<<{s}};
      end
    endcase
    return r;
  endfunction

  // One clock: log handshakes seen before the edge, then sample #1 after.
  task automatic step(output bit ix);
    bit ox;
    ix = !reset && (in_valid === 1'b1) && (in_ready === 1'b1);
    ox = !reset && (out_valid === 1'b1) && (out_ready === 1'b1);
    if (ox) got_q.push_back(out_data);
    if (ix) exp_q.push_back(ref_perm(in_data, in_mode));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit ix;
    reset = 1'b1;
    in_valid = 1'b0;
    step(ix);
    step(ix);
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic drain(input int budget);
    bit ix;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < budget && got_q.size() < exp_q.size(); c++) step(ix);
  endtask

  task automatic compare_queues(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s count got %0d exp %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s word %0d got %h exp %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    bit ix;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_mode = 2'b00;
    step(ix);
    step(ix);
    checks++;
    if ({out_valid, in_ready, out_data, xfer_count} !== {1'b0, 1'b1, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_held got v=%b r=%b d=%h c=%0d exp v=0 r=1 d=0 c=0",
               out_valid, in_ready, out_data, xfer_count);
    end
    reset = 1'b0;
    step(ix);
    checks++;
    if ({out_valid, in_ready, out_data, xfer_count} !== {1'b0, 1'b1, 32'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_after got v=%b r=%b d=%h c=%0d exp v=0 r=1 d=0 c=0",
               out_valid, in_ready, out_data, xfer_count);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_latency();
    bit ix;
    logic [31:0] din  [2] = '{32'h0000_0001, 32'hDEAD_BEEF};
    logic [1:0]  dmod [2] = '{2'b01, 2'b00};
    logic [31:0] dexp [2] = '{32'h8000_0000, 32'hDEAD_BEEF};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = din[i];
      in_mode = dmod[i];
      step(ix);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== dexp[i]) begin
        errors++;
        $display("FAIL latency_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, dexp[i]);
      end
      step(ix);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_cycle_%0d got v=%b exp v=0", i, out_valid);
      end
    end
    compare_queues("latency_seq");
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_modes();
    bit ix;
    logic [31:0] din  [2] = '{32'h1122_3344, 32'h0180_F00F};
    logic [1:0]  dmod [2] = '{2'b10, 2'b11};
    logic [31:0] dexp [2] = '{32'h4433_2211, 32'h8001_0FF0};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = din[i];
      in_mode = dmod[i];
      step(ix);
      in_valid = 1'b0;
      checks++;
      if (out_data !== dexp[i]) begin
        errors++;
        $display("FAIL mode_const_%0d got %h exp %h", i, out_data, dexp[i]);
      end
      step(ix);
    end
    exp_q.delete();
    got_q.delete();
    // Back-to-back words cycling through every mode.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      in_mode = 2'(i);
      step(ix);
    end
    drain(10);
    compare_queues("mode_b2b");
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    bit ix;
    int stall_bad = 0;
    out_ready = 1'b0;
    in_mode = 2'b00;
    in_valid = 1'b1;
    in_data = 32'd1;
    step(ix);
    checks++;
    if (!ix || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_a got accepted=%b ready=%b exp 1 1", ix, in_ready);
    end
    in_data = 32'd2;
    step(ix);
    checks++;
    if (!ix || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept_b got accepted=%b ready=%b exp 1 0", ix, in_ready);
    end
    in_data = 32'd3;
    for (int c = 0; c < 4; c++) begin
      step(ix);
      if (ix || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd1) stall_bad++;
    end
    checks++;
    if (stall_bad !== 0) begin
      errors++;
      $display("FAIL bp_stall got %0d bad cycles exp 0", stall_bad);
    end
    out_ready = 1'b1;
    ix = 1'b0;
    for (int c = 0; c < 10 && !ix; c++) step(ix);
    checks++;
    if (!ix) begin
      errors++;
      $display("FAIL bp_accept_c got not accepted within 10 cycles exp accepted");
    end
    drain(10);
    checks++;
    if (got_q.size() !== 3 || got_q[0] !== 32'd1 || got_q[1] !== 32'd2 || got_q[2] !== 32'd3) begin
      errors++;
      $display("FAIL bp_order got n=%0d %p exp 1 2 3", got_q.size(), got_q);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic stream_words(input int n, output int gaps, output int refused);
    bit ix;
    gaps = 0;
    refused = 0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      in_mode = 2'($urandom_range(0, 3));
      if (i > 0 && out_valid !== 1'b1) gaps++;
      step(ix);
      if (!ix) refused++;
    end
    drain(10);
  endtask

  task automatic test_streaming();
    int gaps;
    int refused;
    do_reset();
    stream_words(100, gaps, refused);
    checks++;
    if (gaps !== 0 || refused !== 0) begin
      errors++;
      $display("FAIL stream_rate got gaps=%0d refused=%0d exp 0 0", gaps, refused);
    end
    compare_queues("stream_data");
    checks++;
    if (xfer_count !== 16'd100) begin
      errors++;
      $display("FAIL stream_count got %0d exp 100", xfer_count);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_counter_wrap();
    int gaps;
    int refused;
    do_reset();
    stream_words(17, gaps, refused);
    checks++;
    if (w_xfer_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count4 got %0d exp 1", w_xfer_count);
    end
    checks++;
    if (xfer_count !== 16'd17) begin
      errors++;
      $display("FAIL wrap_count16 got %0d exp 17", xfer_count);
    end
    compare_queues("wrap_data");
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_full();
    bit ix;
    int seen = 0;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = 2'b00;
    in_data = 32'hA5A5_0001;
    step(ix);
    in_data = 32'hA5A5_0002;
    step(ix);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rf_full got r=%b v=%b exp r=0 v=1", in_ready, out_valid);
    end
    reset = 1'b1;
    step(ix);
    reset = 1'b0;
    checks++;
    if ({out_valid, in_ready, xfer_count} !== {1'b0, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL rf_after got v=%b r=%b c=%0d exp v=0 r=1 c=0", out_valid, in_ready, xfer_count);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(ix);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rf_no_emit got %0d valid cycles exp 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_backpressure();
    test_streaming();
    test_counter_wrap();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
